// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a CPU data port (0) and a loader/debug port (1).
// Each access is IDLE -> ACCESS (-> RESP for reads); read data returns through a registered rvalid/rdata pulse.
module mem_arbiter #(
    parameter int WORD = 8,
    parameter int ADDR = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req0,
    input  logic            i_req1,
    input  logic            i_we0,
    input  logic            i_we1,
    input  logic [ADDR-1:0] i_addr0,
    input  logic [ADDR-1:0] i_addr1,
    input  logic [WORD-1:0] i_wdata0,
    input  logic [WORD-1:0] i_wdata1,
    output logic            o_gnt0,
    output logic            o_gnt1,
    output logic            o_rvalid0,
    output logic            o_rvalid1,
    output logic [WORD-1:0] o_rdata0,
    output logic [WORD-1:0] o_rdata1,
    output logic [ADDR-1:0] o_mem_addr,
    output logic [WORD-1:0] o_mem_wdata,
    output logic            o_mem_we,
    input  logic [WORD-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last;
    logic            r_owner;
    logic            r_we;
    logic [ADDR-1:0] r_addr;
    logic [WORD-1:0] r_wdata;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic [WORD-1:0] r_rdata0;
    logic [WORD-1:0] r_rdata1;

    logic            w_win;
    logic            w_access;

    // On a tie the port that did not win last time goes first; a lone requester always wins.
    assign w_win    = (i_req0 && i_req1) ? ~r_last : i_req1;
    assign w_access = (r_state == S_ACCESS);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_state <= S_ACCESS;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_we    <= w_win ? i_we1    : i_we0;
                        r_addr  <= w_win ? i_addr1  : i_addr0;
                        r_wdata <= w_win ? i_wdata1 : i_wdata0;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                    end
                end
                S_ACCESS: begin
                    r_state <= r_we ? S_IDLE : S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (r_owner) begin
                        r_rdata1  <= i_mem_rdata;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= i_mem_rdata;
                        r_rvalid0 <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM side is decoded from state so reset clears it without waiting for a clock.
    assign o_mem_we    = w_access & r_we;
    assign o_mem_wdata = w_access ? r_wdata : '0;
    assign o_mem_addr  = (w_access || (r_state == S_RESP)) ? r_addr : '0;

    assign o_gnt0    = r_gnt0;
    assign o_gnt1    = r_gnt1;
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata0  = r_rdata0;
    assign o_rdata1  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter and RAM.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.WORD(8), .ADDR(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
        .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            8'h10:   return 8'h5A;
            8'h20:   return 8'h00;
            8'h30:   return 8'h55;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // RAM attached to the DUT: synchronous write, one-cycle registered read; preloaded on reset.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Transaction model: each access occupies 2 (write) or 3 (read) cycles counted from its arbitration edge.
    logic [7:0] mram [256];
    int         age;
    logic       m_last, t_port, t_we, w;
    logic [7:0] t_addr, t_wdata, t_rd;
    logic       e_gnt0, e_gnt1, e_rv0, e_rv1, e_mwe;
    logic [7:0] e_rd0, e_rd1, e_maddr, e_mwd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age = 99; m_last = 1'b1; t_port = 1'b0; t_we = 1'b0;
            t_addr = 8'h00; t_wdata = 8'h00; t_rd = 8'h00;
            e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_mwe = 0;
            e_rd0 = 0; e_rd1 = 0; e_maddr = 0; e_mwd = 0;
            for (int i = 0; i < 256; i++) mram[i] = init_val(i);
        end else begin
            if (age >= (t_we ? 2 : 3) && (req0 || req1)) begin
                w       = (req0 && req1) ? !m_last : req1;
                m_last  = w;
                t_port  = w;
                t_we    = w ? we1 : we0;
                t_addr  = w ? addr1 : addr0;
                t_wdata = w ? wdata1 : wdata0;
                if (t_we) mram[t_addr] = t_wdata;
                else      t_rd = mram[t_addr];
                age = 0;
            end
            if (age < 99) age++;
            e_gnt0  = (age == 1) && !t_port;
            e_gnt1  = (age == 1) &&  t_port;
            e_mwe   = (age == 1) && t_we;
            e_mwd   = (age == 1) ? t_wdata : 8'h00;
            e_maddr = (age == 1 || (age == 2 && !t_we)) ? t_addr : 8'h00;
            e_rv0   = (age == 3) && !t_we && !t_port;
            e_rv1   = (age == 3) && !t_we &&  t_port;
            if (e_rv0) e_rd0 = t_rd;
            if (e_rv1) e_rd1 = t_rd;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            if ({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_we, mem_wdata} !==
                {e_gnt0, e_gnt1, e_rv0, e_rv1, e_rd0, e_rd1, e_maddr, e_mwe, e_mwd}) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t got gnt=%b%b rv=%b%b rd0=%h rd1=%h ma=%h we=%b wd=%h; expected gnt=%b%b rv=%b%b rd0=%h rd1=%h ma=%h we=%b wd=%h",
                         $time, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_addr, mem_we, mem_wdata,
                         e_gnt0, e_gnt1, e_rv0, e_rv1, e_rd0, e_rd1, e_maddr, e_mwe, e_mwd);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int         g_cyc[$];
    int         g_port[$];
    logic       seen;
    logic [5:0] mask;

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_flags", {gnt0, gnt1, rvalid0, rvalid1, mem_we}, 0);
        chk("reset_rdata", {rdata0, rdata1}, 0);
        chk("reset_maddr", mem_addr, 0);
        rst = 1'b0;

        // single read of 0x10 by port 0
        step();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        step();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_maddr_n1", mem_addr, 8'h10);
        req0 = 0;
        step();
        chk("rd_maddr_n2", mem_addr, 8'h10);
        step();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 8'h5A);
        step(); step(); step();
        chk("rd_rdata0_hold", rdata0, 8'h5A);

        // port 1 write 0xC3 to 0xFF, then read back
        req1 = 1; we1 = 1; addr1 = 8'hFF; wdata1 = 8'hC3;
        step();
        chk("wr_gnt1", gnt1, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_wdata", mem_wdata, 8'hC3);
        req1 = 0;
        step();
        chk("wr_mem_we_off", mem_we, 0);
        req1 = 1; we1 = 0;
        step();
        chk("rb_gnt1", gnt1, 1);
        chk("rb_mem_we", mem_we, 0);
        req1 = 0;
        step(); step();
        chk("rb_rvalid1", rvalid1, 1);
        chk("rb_rdata1", rdata1, 8'hC3);
        chk("rb_rvalid0", rvalid0, 0);

        // both ports reading continuously
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h01; addr1 = 8'h02;
        for (int i = 1; i <= 16 && g_port.size() < 4; i++) begin
            step();
            if (gnt0) begin g_cyc.push_back(i); g_port.push_back(0); end
            if (gnt1) begin g_cyc.push_back(i); g_port.push_back(1); end
            if (g_port.size() >= 4) begin req0 = 0; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        chk("tie_count", g_port.size(), 4);
        if (g_port.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("tie_order", g_port[k], k % 2);
            for (int k = 1; k < 4; k++) chk("tie_spacing", g_cyc[k] - g_cyc[k-1], 3);
        end
        step(); step(); step();

        // inputs changed after grant must not affect the latched access
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h11;
        step();
        chk("late_gnt0", gnt0, 1);
        addr0 = 8'h30; wdata0 = 8'h22; req0 = 0;
        step(); step();
        chk("late_ram20", ram[8'h20], 8'h11);
        chk("late_ram30", ram[8'h30], 8'h55);

        // reset during RESP of a port 1 read
        req1 = 1; we1 = 0; addr1 = 8'h10;
        step();
        req1 = 0;
        step();
        rst = 1'b1;
        #1;
        chk("rst_flags", {gnt0, gnt1, rvalid0, rvalid1, mem_we}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        chk("rst_maddr", mem_addr, 0);
        step();
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            step();
            seen = seen | rvalid0 | rvalid1;
        end
        chk("rst_no_rvalid", seen, 0);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h05; addr1 = 8'h06;
        step();
        chk("rst_tie_gnt", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = gnt1;
        end
        chk("rst_tie_gnt1", seen, 1);
        req1 = 0;
        step(); step(); step();

        // held write request gives back-to-back writes
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h77;
        mask = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 6) req0 = 0;
            mask[i-1] = gnt0;
        end
        chk("held_gnt_mask", mask, 6'b010101);
        step(); step();

        // random traffic checked by the per-cycle compare
        for (int c = 0; c < 3000; c++) begin
            step();
            if (req0) begin
                if (gnt0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        we0 = 1'($urandom_range(0, 1)); addr0 = 8'($urandom); wdata0 = 8'($urandom);
                    end else req0 = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = 8'($urandom); wdata0 = 8'($urandom);
            end
            if (req1) begin
                if (gnt1) begin
                    if ($urandom_range(0, 3) == 0) begin
                        we1 = 1'($urandom_range(0, 1)); addr1 = 8'($urandom); wdata1 = 8'($urandom);
                    end else req1 = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = 8'($urandom); wdata1 = 8'($urandom);
            end
        end
        req0 = 0; req1 = 0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port 256×8 system RAM between two requesters: port 0 is the CPU data port (LW/SW) and port 1 is the program loader/debug port. It sits between the requesters and the RAM. It serialises accesses with round-robin priority and a req/gnt handshake, and returns read data through a registered `rvalid`/`rdata` pulse for each port. The RAM has a synchronous write and a one-cycle registered read.

## Interface
- `WORD`, default 8: data width in bits.
- `ADDR`, default 8: address width in bits (256 locations).

- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `req0` / `req1`  in  1: access request from port 0 / port 1. Hold high until `gnt` is seen.
- `we0` / `we1`  in  1: 1 = write, 0 = read. Sampled with `req`.
- `addr0` / `addr1`  in  ADDR: access address.
- `wdata0` / `wdata1`  in  WORD: write data.
- `gnt0` / `gnt1`  out  1: one-cycle grant pulse, high during the ACCESS cycle.
- `rvalid0` / `rvalid1`  out  1: one-cycle read-data-valid pulse.
- `rdata0` / `rdata1`  out  WORD: read data. Holds its value until the next read completes for that port.
- `mem_addr`  out  ADDR: RAM address.
- `mem_wdata`  out  WORD: RAM write data.
- `mem_we`  out  1: RAM write enable.
- `mem_rdata`  in  WORD: RAM read data, valid in the cycle after the address is presented.

## Operation
- FSM states and transitions:
  - IDLE: at a clock edge, if any `req` is high, pick a winner and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: a write returns to IDLE; a read goes to RESP.
  - RESP: always returns to IDLE.
- Arbitration:
  - When only one port requests, that port wins.
  - When both request, the port not granted last time wins.
  - The `last` pointer resets to 1, so port 0 wins the first tie.
  - `last` updates on each arbitration edge.
- Latching: at the arbitration edge, the winner's `we`, `addr` and `wdata` are latched. Changes on the requester's inputs after that edge are ignored.
- ACCESS outputs:
  - `mem_addr` = latched addr.
  - `mem_we` = latched we.
  - `mem_wdata` = latched wdata.
  - `gnt` of the owner = 1.
- Outside ACCESS:
  - `mem_we` = 0.
  - `mem_addr` = 0 in IDLE.
  - `mem_addr` holds the latched address in RESP.
  - `mem_wdata` = 0.
- RESP: at the edge ending RESP, `mem_rdata` is loaded into the owner's `rdata` register, and that port's `rvalid` register is set for exactly one cycle.
- Requester protocol:
  - A requester drops `req` in the cycle after it sees `gnt`.
  - If `req` is still high when the FSM next evaluates in IDLE, it is treated as a new request. This is legal; it gives back-to-back accesses.
- Reset, asserted at any time:
  - State goes to IDLE, `last` goes to 1, latched fields go to 0.
  - All outputs go to 0, including `rdata0`, `rdata1` and `mem_we`, immediately and asynchronously.
  - An in-flight access is aborted and produces no `rvalid`.

## Timing
Cycle n is the cycle in which `req` is first high while in IDLE.

- Write:
  - n+1: ACCESS, `gnt` = 1, `mem_we` = 1. The RAM writes at the end of n+1.
  - n+2: IDLE.
  - Write cost: 2 cycles.
- Read:
  - n+1: ACCESS, `gnt` = 1, `mem_we` = 0.
  - n+2: RESP, `mem_rdata` is valid.
  - n+3: `rvalid` = 1 and `rdata` is valid. The FSM is in IDLE and may arbitrate in the same cycle.
  - Read latency: 3 cycles from request to `rvalid`.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- Output sources:
  - Registered: `gnt`, `rvalid`, `rdata`.
  - Decoded from state plus latched registers: the `mem_*` outputs.
- Guarantees:
  - No combinational path from `req` to any output.
  - `gnt0` and `gnt1` are never high together.
  - `rvalid0` and `rvalid1` are never high together.

## Test plan
- Reset then a single read: `rst` pulse, RAM[0x10] = 0x5A, port 0 reads 0x10.
  - Required: `gnt0` at n+1; `mem_addr` = 0x10 at n+1 and n+2.
  - Required: `rvalid0` = 1 with `rdata0` = 0x5A at n+3.
  - Required: `rdata0` is still 0x5A at n+6.
- Write then read-back: port 1 writes 0xC3 to 0xFF, then reads 0xFF.
  - Required: `mem_we` = 1 only in the write's ACCESS cycle.
  - Required: `rvalid1` with `rdata1` = 0xC3; `rvalid0` stays 0 throughout.
- Simultaneous requests: both ports request reads every cycle for 4 accesses.
  - Required: grant order 0, 1, 0, 1, with no two `gnt` pulses less than 3 cycles apart.
- Input change after grant: port 0 write to 0x20 with data 0x11. The requester changes `addr0` to 0x30 and `wdata0` to 0x22 in the ACCESS cycle.
  - Required: RAM[0x20] = 0x11; RAM[0x30] is unchanged.
- Reset mid-read: assert `rst` during RESP.
  - Required: `mem_we`, `gnt`, `rvalid` and `rdata` all 0 immediately, and no `rvalid` after release.
  - Required: the next tie after reset is won by port 0.
- Held request: port 0 holds `req0` high for 6 cycles on a write.
  - Required: `gnt0` at cycles 1, 3 and 5, i.e. back-to-back writes at a 2-cycle spacing.
